// File: rtl/point_cloud_buffer_reader.sv
// Unpacks a NUM_PTS-slot buffer into a point stream, oldest slot first; first point 1 cycle after accept.
// Points stall while point_ready is low; a new buffer is taken on the last point's handshake (no bubble).
module point_cloud_buffer_reader #(
  parameter int POINT_W = 128,
  parameter int NUM_PTS = 4,
  parameter int CNT_W   = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic [POINT_W*NUM_PTS-1:0] buffer_in,
  input  logic [CNT_W-1:0]           num_valid,
  input  logic                       buffer_valid,
  output logic                       buffer_ready,
  output logic [POINT_W-1:0]         point_out,
  output logic [$clog2(NUM_PTS)-1:0] point_idx,
  output logic                       point_last,
  output logic                       point_valid,
  input  logic                       point_ready,
  output logic                       empty_drop
);
  localparam int IDX_W = $clog2(NUM_PTS);
  localparam logic [CNT_W-1:0] FULL     = CNT_W'(NUM_PTS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PTS - 1);

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                     state;
  logic [POINT_W*NUM_PTS-1:0] buf_q;
  logic                       take;
  logic                       accept;
  logic [CNT_W-1:0]           nv_clip;
  logic [IDX_W-1:0]           first_idx;
  logic [IDX_W-1:0]           next_idx;

  assign take         = point_valid & point_ready;
  assign buffer_ready = (state == IDLE) | (take & point_last);
  assign accept       = buffer_valid & buffer_ready;
  assign nv_clip      = (num_valid > FULL) ? FULL : num_valid;
  // Valid points occupy the top slots, so the oldest one sits at NUM_PTS - count.
  assign first_idx    = IDX_W'(FULL - nv_clip);
  assign next_idx     = point_idx + IDX_W'(1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      buf_q       <= '0;
      point_out   <= '0;
      point_idx   <= '0;
      point_last  <= 1'b0;
      point_valid <= 1'b0;
      empty_drop  <= 1'b0;
    end else begin
      empty_drop <= 1'b0;
      if (accept) begin
        if (nv_clip == '0) begin
          empty_drop  <= 1'b1;
          point_valid <= 1'b0;
          state       <= IDLE;
        end else begin
          buf_q       <= buffer_in;
          point_out   <= buffer_in[int'(first_idx)*POINT_W +: POINT_W];
          point_idx   <= first_idx;
          point_last  <= (first_idx == LAST_IDX);
          point_valid <= 1'b1;
          state       <= STREAM;
        end
      end else if (take) begin
        if (point_last) begin
          point_valid <= 1'b0;
          state       <= IDLE;
        end else begin
          point_out  <= buf_q[int'(next_idx)*POINT_W +: POINT_W];
          point_idx  <= next_idx;
          point_last <= (next_idx == LAST_IDX);
        end
      end
    end
  end
endmodule

// File: tb/tb_point_cloud_buffer_reader.sv
// Bench for point_cloud_buffer_reader: directed cases plus randomized traffic against a point-queue model.
module tb_point_cloud_buffer_reader;
  logic         clk;
  logic         reset_n;
  logic [511:0] buffer_in;
  logic [2:0]   num_valid;
  logic         buffer_valid;
  logic         buffer_ready;
  logic [127:0] point_out;
  logic [1:0]   point_idx;
  logic         point_last;
  logic         point_valid;
  logic         point_ready;
  logic         empty_drop;

  int checks = 0;
  int errors = 0;
  int obs_hs = 0;
  int rdy_mode = 0;

  typedef struct {
    logic [127:0] d;
    logic [1:0]   i;
    logic         l;
  } pt_t;
  pt_t  q[$];
  logic exp_drop = 1'b0;
  logic pv, hs, br;
  int   n;

  point_cloud_buffer_reader dut (
    .clk(clk), .reset_n(reset_n), .buffer_in(buffer_in), .num_valid(num_valid),
    .buffer_valid(buffer_valid), .buffer_ready(buffer_ready), .point_out(point_out),
    .point_idx(point_idx), .point_last(point_last), .point_valid(point_valid),
    .point_ready(point_ready), .empty_drop(empty_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Offer one buffer and hold it until the reader takes it.
  task automatic send(input logic [511:0] data, input logic [2:0] nv);
    logic taken;
    taken = 1'b0;
    buffer_in = data;
    num_valid = nv;
    buffer_valid = 1'b1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      taken = buffer_ready;
      @(posedge clk);
      #1;
      if (taken) break;
    end
    buffer_valid = 1'b0;
    if (!taken) begin
      checks++;
      errors++;
      $display("FAIL send_timeout actual=not_accepted required=accepted");
    end
  endtask

  task automatic idle(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Downstream ready generator.
  initial begin
    point_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0: point_ready = 1'b1;
        1: point_ready = ~point_ready;
        2: point_ready = ($urandom_range(0, 99) < 70);
        default: point_ready = 1'b0;
      endcase
    end
  end

  // Model: queue of points still owed for the held buffer; its head is the current point.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        chk("rst_point_valid", point_valid, 0);
        chk("rst_point_out", point_out, 0);
        chk("rst_point_idx", point_idx, 0);
        chk("rst_point_last", point_last, 0);
        chk("rst_empty_drop", empty_drop, 0);
        q.delete();
        exp_drop = 1'b0;
      end else begin
        pv = (q.size() > 0);
        chk("point_valid", point_valid, pv);
        if (pv) begin
          chk("point_out", point_out, q[0].d);
          chk("point_idx", point_idx, q[0].i);
          chk("point_last", point_last, q[0].l);
        end
        chk("empty_drop", empty_drop, exp_drop);
        hs = pv && point_ready;
        br = !pv || (hs && q[0].l);
        chk("buffer_ready", buffer_ready, br);
        if (point_valid && point_ready) obs_hs++;
        exp_drop = 1'b0;
        if (hs) void'(q.pop_front());
        if (buffer_valid && br) begin
          n = (num_valid > 3'd4) ? 4 : int'(num_valid);
          if (n == 0) exp_drop = 1'b1;
          else for (int k = 4 - n; k < 4; k++) q.push_back('{buffer_in[k*128 +: 128], 2'(k), (k == 3)});
        end
      end
    end
  end

  initial begin
    logic [511:0] b;
    logic [127:0] p;
    logic [127:0] aa, bb;
    int h0;
    aa = {16{8'hAA}};
    bb = {16{8'hBB}};
    reset_n = 1'b0;
    buffer_in = '0;
    num_valid = '0;
    buffer_valid = 1'b0;
    #1;
    chk("lit_reset_valid", point_valid, 0);
    chk("lit_reset_out", point_out, 0);
    chk("lit_reset_drop", empty_drop, 0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    idle(1);

    // Full buffer, slots 0..3 in order, last only on slot 3.
    for (int k = 0; k < 4; k++) b[k*128 +: 128] = {4{32'hA500_0000 | k}};
    send(b, 3'd4);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      p = {4{32'hA500_0000 | k}};
      chk("lit_full_valid", point_valid, 1);
      chk("lit_full_out", point_out, p);
      chk("lit_full_idx", point_idx, k);
      chk("lit_full_last", point_last, (k == 3));
      chk("lit_full_bready", buffer_ready, (k == 3));
    end
    @(negedge clk);
    chk("lit_full_done", point_valid, 0);
    idle(1);

    // Partial buffer: only the top two slots.
    b = rnd512();
    b[256 +: 128] = aa;
    b[384 +: 128] = bb;
    send(b, 3'd2);
    @(negedge clk);
    chk("lit_part_out0", point_out, aa);
    chk("lit_part_idx0", point_idx, 2);
    chk("lit_part_last0", point_last, 0);
    @(negedge clk);
    chk("lit_part_out1", point_out, bb);
    chk("lit_part_idx1", point_idx, 3);
    chk("lit_part_last1", point_last, 1);
    @(negedge clk);
    chk("lit_part_done", point_valid, 0);
    idle(1);

    // Back-to-back buffers: eight consecutive valid points.
    send(rnd512(), 3'd4);
    fork
      send(rnd512(), 3'd4);
      begin
        for (int i = 0; i < 8; i++) begin
          @(negedge clk);
          chk("lit_b2b_valid", point_valid, 1);
        end
      end
    join
    @(negedge clk);
    chk("lit_b2b_done", point_valid, 0);
    idle(1);

    // Stalls: toggling ready, then ready held low for 5 cycles.
    h0 = obs_hs;
    rdy_mode = 1;
    send(rnd512(), 3'd4);
    send(rnd512(), 3'd3);
    idle(10);
    rdy_mode = 3;
    send(rnd512(), 3'd4);
    idle(5);
    rdy_mode = 0;
    idle(10);
    chk("lit_stall_count", obs_hs - h0, 11);

    // Empty buffer is dropped; oversize count clips to a full buffer.
    send(rnd512(), 3'd0);
    @(negedge clk);
    chk("lit_drop_pulse", empty_drop, 1);
    chk("lit_drop_novalid", point_valid, 0);
    @(negedge clk);
    chk("lit_drop_end", empty_drop, 0);
    idle(1);
    send(rnd512(), 3'd7);
    @(negedge clk);
    chk("lit_clip_idx", point_idx, 0);
    chk("lit_clip_valid", point_valid, 1);
    idle(6);

    // Asynchronous reset after the second point.
    send(rnd512(), 3'd4);
    @(posedge clk);
    #1;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("lit_areset_valid", point_valid, 0);
    chk("lit_areset_out", point_out, 0);
    chk("lit_areset_idx", point_idx, 0);
    chk("lit_areset_last", point_last, 0);
    @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    chk("lit_post_rst_bready", buffer_ready, 1);
    chk("lit_post_rst_valid", point_valid, 0);
    idle(1);
    send(rnd512(), 3'd4);
    @(negedge clk);
    chk("lit_post_rst_idx", point_idx, 0);
    idle(6);

    // Randomized traffic.
    rdy_mode = 2;
    repeat (300) begin
      send(rnd512(), 3'($urandom_range(0, 7)));
      idle($urandom_range(0, 2));
    end
    rdy_mode = 0;
    idle(10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
